mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have clk  in  1  rising-edge clock.
REQ-002 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have mem_aluop in 8, mem_wa in 5, mem_wd in 32 (ALU result / effective address), mem_wreg in 1, mem_mreg in 1, mem_whilo in 1, mem_din in 32 (store data), mem_hilo in 64, mem_pc in 32, mem_in_delay in 1, mem_exccode in 5 (5'h10 = none), flush in 1.
REQ-004 SHALL have data bus dm_req out 1, dm_we out 1, dm_be out 4, dm_addr out 32, dm_wdata out 32, dm_ack in 1, dm_rdata in 32.
REQ-005 SHALL have write-back outputs wb_wa out 5, wb_wreg out 1, wb_wd out 32, wb_whilo out 1, wb_hilo out 64.
REQ-006 SHALL have stallreq_mem out 1, exc_code out 5, exc_pc out 32, exc_in_delay out 1, exc_badvaddr out 32.

Function
REQ-007 SHALL decode memory ops: LB 8'h90, LBU 8'h91, LH 8'h92, LHU 8'h93, LW 8'h94, SB 8'h98, SH 8'h99, SW 8'h9A; all other codes, including bubble 8'h11, are non-memory.
REQ-008 SHALL pass non-memory ops combinationally: wb_* = mem_* fields, no bus activity, stallreq_mem=0.
REQ-009 SHALL, if mem_exccode!=5'h10, output it on exc_code and issue no bus access.
REQ-010 SHALL raise alignment exceptions: LH/LHU with addr[0]!=0, or LW with addr[1:0]!=0 -> exc_code 5'h04; SH with addr[0]!=0, or SW with addr[1:0]!=0 -> 5'h05; exc_badvaddr=mem_wd; no bus access.
REQ-011 SHALL, on any exception, force wb_wreg=0 and wb_whilo=0, and drive exc_pc=mem_pc, exc_in_delay=mem_in_delay; an incoming exccode has priority over alignment.
REQ-012 SHALL use FSM states IDLE, WAIT, DONE.
REQ-013 IDLE + valid memory op without exception: SHALL capture wa, aluop, addr, mreg, wreg and store data into internal registers; assert dm_req and stallreq_mem in that cycle; go to DONE if dm_ack=1, else WAIT.
REQ-014 WAIT: SHALL hold dm_req=1 with stable dm_addr/dm_we/dm_be/dm_wdata from the captured registers; stallreq_mem=1; on dm_ack go to DONE.
REQ-015 On the dm_ack cycle, SHALL register dm_rdata.
REQ-016 DONE: SHALL drive wb_* from the captured registers and extended load data; stallreq_mem=0; dm_req=0; go to IDLE.
REQ-017 Latency: a memory op SHALL occupy (cycles to ack)+1 cycles; minimum 2.
REQ-018 Addressing: SHALL drive dm_addr = {addr[31:2],2'b00} and be little-endian.
REQ-019 SB SHALL drive be = 4'b0001<<addr[1:0] and wdata = {4{din[7:0]}}.
REQ-020 SH SHALL drive be = addr[1] ? 4'b1100 : 4'b0011 and wdata = {2{din[15:0]}}.
REQ-021 SW SHALL drive be = 4'b1111 and wdata = din.
REQ-022 Loads SHALL use be = 4'b1111 and dm_we=0.
REQ-023 Load extension SHALL select the lane by addr; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-024 Stores SHALL force wb_wreg=0.
REQ-025 flush while IDLE or DONE: SHALL return to IDLE next cycle and drop the result.
REQ-026 flush while WAIT: SHALL keep dm_req until ack (no withdrawal), set a kill flag, and in DONE force wb_wreg=0.
REQ-027 The kill flag SHALL clear on entry to IDLE.
REQ-028 While not in IDLE, SHALL ignore mem_* input changes.

Reset
REQ-029 On rst=1 at a clk edge, SHALL enter IDLE and clear the captured registers, rdata register and kill flag.
REQ-030 After reset, outputs SHALL reflect pass-through of the mem_* inputs; dm_req=0, stallreq_mem=0.
REQ-031 rst during WAIT SHALL abort immediately; a late dm_ack SHALL be ignored.

Structure
REQ-032 The aluop codes, exccodes 5'h10/5'h04/5'h05 and FSM state encodings SHALL live in the shared mips32 defines package.
REQ-033 SHALL instantiate one combinational sub-module mem_lane (be/wdata generation and load extract/extend).

Verification
REQ-034 LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> stallreq_mem high 3 cycles; DONE wb_wd=0xDEADBEEF, wb_wreg=1.
REQ-035 LB addr 0x103, rdata 0x80112233, immediate ack -> wb_wd=0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x202, din 0x0000ABCD -> dm_be=4'b1100, dm_wdata=0xABCDABCD, dm_addr=0x200, wb_wreg=0.
REQ-037 LW addr 0x101 -> exc_code=5'h04, exc_badvaddr=0x101, no dm_req, wb_wreg=0; incoming exccode 5'h08 with same op -> exc_code=5'h08.
REQ-038 flush in WAIT, then ack -> dm_req held to ack, DONE wb_wreg=0; rst in WAIT -> IDLE next cycle, dm_req=0.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared mips32 defines: memory-stage ALU op codes, exception codes and
// the memory-access FSM state encoding.
package mips32_pkg;

    localparam logic [7:0] OP_NOP = 8'h11;
    localparam logic [7:0] OP_LB  = 8'h90;
    localparam logic [7:0] OP_LBU = 8'h91;
    localparam logic [7:0] OP_LH  = 8'h92;
    localparam logic [7:0] OP_LHU = 8'h93;
    localparam logic [7:0] OP_LW  = 8'h94;
    localparam logic [7:0] OP_SB  = 8'h98;
    localparam logic [7:0] OP_SH  = 8'h99;
    localparam logic [7:0] OP_SW  = 8'h9A;

    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
            default:             is_mem_op = 1'b0;
        endcase
    endfunction

    // Alignment check on the effective address; EXC_NONE when aligned.
    function automatic logic [4:0] align_exc(input logic [7:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU: align_exc = a[0]       ? EXC_ADEL : EXC_NONE;
            OP_LW:         align_exc = (a != 2'b00) ? EXC_ADEL : EXC_NONE;
            OP_SH:         align_exc = a[0]       ? EXC_ADES : EXC_NONE;
            OP_SW:         align_exc = (a != 2'b00) ? EXC_ADES : EXC_NONE;
            default:       align_exc = EXC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lane.sv
// Byte-lane logic: store byte-enable/data replication and little-endian
// load lane extraction with sign/zero extension.
module mem_lane
    import mips32_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] din_i,
    input  logic [31:0] rdata_i,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        we_o     = 1'b0;
        be_o     = 4'b1111;
        wdata_o  = '0;
        ldata_o  = '0;
        case (aluop_i)
            OP_LB:  ldata_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: ldata_o = {24'h000000, byte_sel};
            OP_LH:  ldata_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU: ldata_o = {16'h0000, half_sel};
            OP_LW:  ldata_o = rdata_i;
            OP_SB: begin
                we_o    = 1'b1;
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{din_i[7:0]}};
            end
            OP_SH: begin
                we_o    = 1'b1;
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{din_i[15:0]}};
            end
            OP_SW: begin
                we_o    = 1'b1;
                wdata_o = din_i;
            end
            default: be_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory stage: pass-through of non-memory ops, alignment/incoming
// exceptions, and a stalling request/ack data-bus access FSM.
module mem_stage
    import mips32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_aluop,
    input  logic [4:0]  mem_wa,
    input  logic [31:0] mem_wd,
    input  logic        mem_wreg,
    input  logic        mem_mreg,
    input  logic        mem_whilo,
    input  logic [31:0] mem_din,
    input  logic [63:0] mem_hilo,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay,
    input  logic [4:0]  mem_exccode,
    input  logic        flush,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  wb_wa,
    output logic        wb_wreg,
    output logic [31:0] wb_wd,
    output logic        wb_whilo,
    output logic [63:0] wb_hilo,
    output logic        stallreq_mem,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        exc_in_delay,
    output logic [31:0] exc_badvaddr
);

    mem_state_t  state_q, state_d;
    logic [7:0]  aluop_q;
    logic [4:0]  wa_q;
    logic [31:0] addr_q, din_q, rdata_q;
    logic        wreg_q, mreg_q, kill_q;

    logic        idle, exc_in, exc_any, start;
    logic [4:0]  align_code;
    logic [7:0]  l_aluop;
    logic [31:0] l_addr, l_din;
    logic        lane_we;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_ldata;

    assign idle       = (state_q == S_IDLE);
    assign align_code = align_exc(mem_aluop, mem_wd[1:0]);
    assign exc_in     = (mem_exccode != EXC_NONE);
    assign exc_any    = idle && (exc_in || align_code != EXC_NONE);
    assign start      = idle && is_mem_op(mem_aluop) && !exc_any && !flush;

    // The lane sees live inputs on the launch cycle, captured values afterwards.
    assign l_aluop = idle ? mem_aluop : aluop_q;
    assign l_addr  = idle ? mem_wd    : addr_q;
    assign l_din   = idle ? mem_din   : din_q;

    mem_lane u_lane (
        .aluop_i   (l_aluop),
        .addr_lo_i (l_addr[1:0]),
        .din_i     (l_din),
        .rdata_i   (rdata_q),
        .we_o      (lane_we),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .ldata_o   (lane_ldata)
    );

    always_comb begin
        state_d      = state_q;
        dm_req       = 1'b0;
        dm_we        = 1'b0;
        dm_be        = '0;
        dm_addr      = '0;
        dm_wdata     = '0;
        stallreq_mem = 1'b0;
        wb_wa        = mem_wa;
        wb_wreg      = mem_wreg;
        wb_wd        = mem_wd;
        wb_whilo     = mem_whilo;
        wb_hilo      = mem_hilo;
        exc_code     = EXC_NONE;
        exc_pc       = mem_pc;
        exc_in_delay = mem_in_delay;
        exc_badvaddr = '0;
        case (state_q)
            S_IDLE: begin
                if (exc_any) begin
                    wb_wreg      = 1'b0;
                    wb_whilo     = 1'b0;
                    exc_code     = exc_in ? mem_exccode : align_code;
                    exc_badvaddr = exc_in ? '0 : mem_wd;
                end else if (start) begin
                    dm_req       = 1'b1;
                    dm_we        = lane_we;
                    dm_be        = lane_be;
                    dm_addr      = {l_addr[31:2], 2'b00};
                    dm_wdata     = lane_wdata;
                    stallreq_mem = 1'b1;
                    wb_wreg      = 1'b0;
                    wb_whilo     = 1'b0;
                    state_d      = dm_ack ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                dm_req       = 1'b1;
                dm_we        = lane_we;
                dm_be        = lane_be;
                dm_addr      = {l_addr[31:2], 2'b00};
                dm_wdata     = lane_wdata;
                stallreq_mem = 1'b1;
                wb_wa        = wa_q;
                wb_wreg      = 1'b0;
                wb_whilo     = 1'b0;
                if (dm_ack) state_d = S_DONE;
            end
            S_DONE: begin
                wb_wa    = wa_q;
                wb_wd    = mreg_q ? lane_ldata : addr_q;
                wb_wreg  = wreg_q && !lane_we && !kill_q && !flush;
                wb_whilo = 1'b0;
                wb_hilo  = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            aluop_q <= '0;
            wa_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wreg_q  <= 1'b0;
            mreg_q  <= 1'b0;
            rdata_q <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                aluop_q <= mem_aluop;
                wa_q    <= mem_wa;
                addr_q  <= mem_wd;
                din_q   <= mem_din;
                wreg_q  <= mem_wreg;
                mreg_q  <= mem_mreg;
            end
            if ((start || state_q == S_WAIT) && dm_ack) rdata_q <= dm_rdata;
            if (state_d == S_IDLE)                     kill_q <= 1'b0;
            else if (state_q == S_WAIT && flush)       kill_q <= 1'b1;
        end
    end

endmodule
